// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: handshake and data bundle between the ID/EX register and the
// EX-stage multiply/divide unit.
//   start/funct3/op_a/op_b/flush : issue side (pipeline -> unit)
//   stall                        : combinational freeze request (unit -> pipeline)
//   busy/done/result             : registered status and result (unit -> EX/MEM)
interface ex_muldiv_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  // Pipeline side
  modport master (
    output start, funct3, op_a, op_b, flush,
    input  stall, busy, done, result
  );

  // Multiply/divide unit side
  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : ex_muldiv_if.slave (start, funct3, op_a, op_b, flush in;
//           stall (comb), busy, done, result (registered) out)
// Multiplies by 32-step shift-add and divides by 32-step restoring division,
// both on operand magnitudes, with sign correction on the final step.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module ex_muldiv (
  input  logic        clk,
  input  logic        reset,
  ex_muldiv_if.slave  bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 5;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [2:0]      op_q;
  logic            sign_a_q;
  logic            sign_b_q;
  logic [XLEN-1:0] mag_b_q;   // multiplicand / divisor magnitude
  logic [XLEN-1:0] hi_q;      // product high half / partial remainder
  logic [XLEN-1:0] lo_q;      // multiplier->product low half / dividend->quotient
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  // Issue-time decode of signedness, magnitudes and the one-cycle special cases
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    is_div   = bus.funct3[2];
    // MUL/MULH/MULHSU treat op_a as signed; MUL/MULH treat op_b as signed
    a_signed = is_div ? !bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    b_signed = is_div ? !bus.funct3[0] : !bus.funct3[1];
    sign_a   = a_signed & bus.op_a[XLEN-1];
    sign_b   = b_signed & bus.op_b[XLEN-1];
    mag_a    = sign_a ? XLEN'(-bus.op_a) : bus.op_a;
    mag_b    = sign_b ? XLEN'(-bus.op_b) : bus.op_b;
    div_zero = is_div && (bus.op_b == '0);
    div_ovf  = is_div && !bus.funct3[0] && (bus.op_a == 32'h8000_0000) &&
               (bus.op_b == 32'hFFFF_FFFF);
    fast_res = '0;
    if (div_zero) begin
      fast_res = bus.funct3[1] ? bus.op_a : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      fast_res = bus.funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  // One iteration of shift-add or restoring division, plus the sign-corrected result
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [XLEN-1:0]   hi_n;
  logic [XLEN-1:0]   lo_n;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, mag_b_q};
    // Remainder after a successful subtract is below the divisor, so 32 bits hold it
    div_sub   = div_shift[XLEN-1:0] - mag_b_q;
    if (op_q[2]) begin
      hi_n = div_ge ? div_sub : div_shift[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod = {hi_n, lo_n};
    if (sign_a_q ^ sign_b_q) prod = (2*XLEN)'(-prod);
    quot = (sign_a_q ^ sign_b_q) ? XLEN'(-lo_n) : lo_n;
    rem  = sign_a_q ? XLEN'(-hi_n) : hi_n;
    if (op_q[2]) begin
      final_res = op_q[1] ? rem : quot;
    end else begin
      final_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start && !bus.flush) begin
            op_q <= bus.funct3;
            if (div_zero || div_ovf) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              sign_a_q <= sign_a;
              sign_b_q <= sign_b;
              mag_b_q  <= mag_b;
              hi_q     <= '0;
              lo_q     <= mag_a;
              count    <= CW'(XLEN - 1);
              busy_q   <= 1'b1;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            if (count == '0) begin
              result_q <= final_res;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state    <= DONE;
            end else begin
              count <= count - CW'(1);
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Freeze the front end from acceptance until the last iteration; low during DONE
  assign bus.stall  = !reset &&
                      (((state == IDLE) && bus.start && !bus.flush) || (state == CALC));
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule
